incr_step_ctrl: RTL and testbench

- Sequential control stage wrapped around the 4-bit combinational incrementer.
- Holds the current count in a register and drives it to the incrementer input. Captures the incrementer output as the next count.
- Emits each count value downstream over a valid/ready handshake, from a programmable start value up to a programmable limit, in either one-shot or free-running mode.

---
 rtl/incr_step_ctrl_if.sv | 29 ++
 rtl/incr_step_ctrl.sv | 155 +++++++++++++++
 tb/tb_incr_step_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/incr_step_ctrl_if.sv
// Handshake and datapath bundle between the step controller and its environment.
// The master side supplies the control requests, the incrementer result and
// downstream ready. The slave side is the controller.
interface incr_step_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] base_val;
  logic [WIDTH-1:0] limit_val;
  logic             mode;
  logic [WIDTH-1:0] inc_in;
  logic [WIDTH-1:0] inc_out;
  logic [WIDTH-1:0] cnt_data;
  logic             cnt_valid;
  logic             cnt_ready;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, base_val, limit_val, mode, inc_out, cnt_ready,
    input  inc_in, cnt_data, cnt_valid, busy, done
  );

  modport slave (
    input  start, abort, base_val, limit_val, mode, inc_out, cnt_ready,
    output inc_in, cnt_data, cnt_valid, busy, done
  );
endinterface

// File: rtl/incr_step_ctrl.sv
// Sequential control stage around an external WIDTH-bit incrementer.
// Streams count values from base to limit over valid/ready, either once
// (ending with a one-cycle done pulse) or repeatedly until aborted.
// All status outputs are registered, so nothing downstream sees a combinational
// path from inc_out.
module incr_step_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  incr_step_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_s;
  logic [WIDTH-1:0] base_r;
  logic [WIDTH-1:0] limit_r;
  logic             mode_r;
  logic             valid_r;
  logic             busy_r;
  logic             done_r;
  logic             valid_s;
  logic             busy_s;
  logic             done_s;
  logic             accept_s;
  logic             load_s;
  logic             xfer_s;
  logic             at_limit_s;

  // start is only meaningful while idle, and abort beats it.
  assign accept_s   = bus.start & ~bus.abort;
  assign load_s     = (state_r == S_IDLE) & accept_s;
  // valid_r is high exactly in RUN, so it doubles as the RUN qualifier here.
  assign xfer_s     = valid_r & bus.cnt_ready;
  assign at_limit_s = (count_r == limit_r);

  assign bus.inc_in    = count_r;
  assign bus.cnt_data  = count_r;
  assign bus.cnt_valid = valid_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; abort overrides both start and the limit transition.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_s = S_RUN;
        else          state_s = S_IDLE;
      end
      S_RUN: begin
        if (bus.abort)                             state_s = S_IDLE;
        else if (xfer_s && at_limit_s && !mode_r)  state_s = S_DONE;
        else                                       state_s = S_RUN;
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Next count: load base on start, step through the incrementer on each
  // transfer, reload base at the limit in free-run, hold otherwise.
  always_comb begin
    count_s = count_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) count_s = bus.base_val;
        else          count_s = count_r;
      end
      S_RUN: begin
        if (!xfer_s)         count_s = count_r;
        else if (!at_limit_s) count_s = bus.inc_out;
        else if (mode_r)     count_s = base_r;
        else                 count_s = count_r;
      end
      default: begin
        count_s = count_r;
      end
    endcase
  end

  // Output decode from the upcoming state so the flops line up with it.
  always_comb begin
    valid_s = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_s)
      S_IDLE: begin
        valid_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
      S_RUN: begin
        valid_s = 1'b1;
        busy_s  = 1'b1;
        done_s  = 1'b0;
      end
      S_DONE: begin
        valid_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b1;
      end
      default: begin
        valid_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // Count, sequence configuration and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {WIDTH{1'b0}};
      base_r  <= {WIDTH{1'b0}};
      limit_r <= {WIDTH{1'b0}};
      mode_r  <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      count_r <= count_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      if (load_s) begin
        base_r  <= bus.base_val;
        limit_r <= bus.limit_val;
        mode_r  <= bus.mode;
      end
    end
  end

endmodule

// File: tb/tb_incr_step_ctrl.sv
// Scoreboard bench for incr_step_ctrl: expected counts are queued when a
// sequence is started and compared at every accepted handshake.
module tb_incr_step_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   cycles;
  logic [3:0] exp_q[$];

  incr_step_ctrl_if #(.WIDTH(4)) bus ();

  incr_step_ctrl #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural incrementer.
  assign bus.inc_out = bus.inc_in + 4'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected values for the given number of passes, then pulse start.
  task automatic do_start(input logic [3:0] b, input logic [3:0] l, input logic m, input int passes);
    logic [3:0] v;
    for (int p = 0; p < passes; p++) begin
      v = b;
      exp_q.push_back(v);
      while (v != l) begin
        v = v + 4'd1;
        exp_q.push_back(v);
      end
    end
    bus.base_val  = b;
    bus.limit_val = l;
    bus.mode      = m;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  // Wait (bounded) for done; check latency, pulse width and return to idle.
  task automatic wait_done(input string tag, input int exp_cycles);
    cycles = 0;
    while (cycles < 40 && bus.done !== 1'b1) begin
      tick();
      cycles++;
    end
    check({tag, "_done_latency"}, cycles, exp_cycles);
    check({tag, "_done_valid_low"}, bus.cnt_valid, 1'b0);
    tick();
    check({tag, "_done_one_cycle"}, bus.done, 1'b0);
    check({tag, "_idle_busy"}, bus.busy, 1'b0);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // Transfer monitor: the handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.cnt_valid === 1'b1 && bus.cnt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", exp_q.size(), 1);
      end else begin
        check("cnt_data", bus.cnt_data, exp_q[0]);
        check("inc_in", bus.inc_in, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.base_val  = 4'd0;
    bus.limit_val = 4'd0;
    bus.mode      = 1'b0;
    bus.cnt_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", bus.cnt_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_count", bus.cnt_data, 4'd0);
    rst = 1'b0;
    tick();

    // One-shot 3..7 at full throughput.
    do_start(4'd3, 4'd7, 1'b0, 1);
    check("os_busy", bus.busy, 1'b1);
    check("os_first", bus.cnt_data, 4'd3);
    wait_done("os", 5);

    // Backpressure: hold at 1 for three cycles.
    do_start(4'd0, 4'd2, 1'b0, 1);
    tick();
    bus.cnt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_data", bus.cnt_data, 4'd1);
      check("bp_hold_valid", bus.cnt_valid, 1'b1);
    end
    bus.cnt_ready = 1'b1;
    wait_done("bp", 2);

    // Wrap through 15 -> 0.
    do_start(4'd14, 4'd1, 1'b0, 1);
    wait_done("wrap", 4);

    // Free-run 5,6,5,6 with a stray start in RUN and abort during the fourth transfer.
    do_start(4'd5, 4'd6, 1'b1, 2);
    tick();
    bus.base_val = 4'd0;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    check("fr_ignore_start", bus.cnt_data, 4'd5);
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("fr_abort_valid", bus.cnt_valid, 1'b0);
    check("fr_abort_busy", bus.busy, 1'b0);
    check("fr_abort_done", bus.done, 1'b0);
    tick();
    check("fr_no_done", bus.done, 1'b0);
    check("fr_stay_idle", bus.cnt_valid, 1'b0);
    check("fr_sb_empty", exp_q.size(), 0);

    // Single value, one-shot.
    do_start(4'd9, 4'd9, 1'b0, 1);
    wait_done("single", 1);

    // Single value, free-run: four transfers of 9, then abort with ready low.
    do_start(4'd9, 4'd9, 1'b1, 4);
    for (int i = 0; i < 4; i++) tick();
    check("single_fr_data", bus.cnt_data, 4'd9);
    bus.cnt_ready = 1'b0;
    bus.abort     = 1'b1;
    tick();
    bus.abort     = 1'b0;
    bus.cnt_ready = 1'b1;
    check("single_fr_idle", bus.busy, 1'b0);
    check("single_fr_sb_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of a run.
    do_start(4'd2, 4'd12, 1'b0, 1);
    tick();
    tick();
    check("mid_count_before", bus.cnt_data, 4'd4);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", bus.cnt_valid, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_done", bus.done, 1'b0);
    check("mid_rst_count", bus.cnt_data, 4'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_idle_valid", bus.cnt_valid, 1'b0);
      check("post_rst_idle_done", bus.done, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
